// File: rtl/mips_fe_pkg.sv
// Shared front-end definitions: fetch/issue widths, aligner valid-mask encodings
// and the leading-ones push-count helper.
package mips_fe_pkg;
  localparam int FETCH_WIDTH = 4;
  localparam int ISSUE_WIDTH = 2;

  localparam logic [FETCH_WIDTH-1:0] VALID_1 = 4'b1000;
  localparam logic [FETCH_WIDTH-1:0] VALID_2 = 4'b1100;
  localparam logic [FETCH_WIDTH-1:0] VALID_3 = 4'b1110;
  localparam logic [FETCH_WIDTH-1:0] VALID_4 = 4'b1111;

  // Count of contiguous ones from bit 3; anything after the first zero is ignored.
  function automatic logic [2:0] lead_ones4(input logic [FETCH_WIDTH-1:0] mask);
    if (!mask[3]) return 3'd0;
    if (!mask[2]) return 3'd1;
    if (!mask[1]) return 3'd2;
    if (!mask[0]) return 3'd3;
    return 3'd4;
  endfunction
endpackage

// File: rtl/insn_queue.sv
// Front-end instruction queue: 4-wide push from the aligner, 2-wide FWFT pop to dispatch.
// Optional INSN_QUEUE_STATS_EN adds o_stall_cycles (rejected-group cycle counter).
module insn_queue
  import mips_fe_pkg::*;
#(
  parameter int INSN_WIDTH = 99,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Flush,
  input  logic [3:0]            i_valid,
  input  logic [INSN_WIDTH-1:0] i_isn1,
  input  logic [INSN_WIDTH-1:0] i_isn2,
  input  logic [INSN_WIDTH-1:0] i_isn3,
  input  logic [INSN_WIDTH-1:0] i_isn4,
  output logic                  o_Stall,
  output logic [1:0]            o_valid,
  output logic [INSN_WIDTH-1:0] o_isn1,
  output logic [INSN_WIDTH-1:0] o_isn2,
  input  logic [1:0]            i_pop,
`ifdef INSN_QUEUE_STATS_EN
  output logic [31:0]           o_stall_cycles,
`endif
  output logic [PTR_W:0]        o_count
);
  localparam logic [PTR_W:0] STALL_LIM = (PTR_W+1)'(DEPTH - FETCH_WIDTH);

  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [INSN_WIDTH-1:0] isn_in [FETCH_WIDTH];
  logic [PTR_W-1:0]      head, tail;
  logic [PTR_W:0]        count;
  logic [2:0]            push_n;
  logic [1:0]            pop_n;

  assign isn_in[0] = i_isn1;
  assign isn_in[1] = i_isn2;
  assign isn_in[2] = i_isn3;
  assign isn_in[3] = i_isn4;

  // Stall looks only at registered occupancy so it never depends on dispatch timing.
  assign o_Stall = count > STALL_LIM;
  assign o_valid = {count != '0, count > (PTR_W+1)'(1)};
  assign o_count = count;
  assign o_isn1  = mem[head];
  assign o_isn2  = mem[head + PTR_W'(1)];

  assign push_n = o_Stall ? 3'd0 : lead_ones4(i_valid);

  always_comb begin
    pop_n = 2'd0;
    if (i_pop[1] && o_valid[1])
      pop_n = (i_pop[0] && o_valid[0]) ? 2'd2 : 2'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

  // Storage has no reset; stale entries are masked by o_valid.
  always_ff @(posedge i_Clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (!i_Reset && !i_Flush && (3'(k) < push_n))
        mem[tail + PTR_W'(k)] <= isn_in[k];
    end
  end

`ifdef INSN_QUEUE_STATS_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      o_stall_cycles <= '0;
    else if (o_Stall && i_valid[3] && (o_stall_cycles != 32'hFFFF_FFFF))
      o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_insn_queue.sv
// Scoreboard bench for insn_queue: model FIFO of tags drives expected head entries,
// occupancy, stall and (with INSN_QUEUE_STATS_EN) the stall counter.
module tb_insn_queue;
  localparam int W = 99;
  localparam int D = 16;

  logic          i_Clk = 1'b0;
  logic          i_Reset, i_Flush;
  logic [3:0]    i_valid;
  logic [W-1:0]  i_isn1, i_isn2, i_isn3, i_isn4;
  logic          o_Stall;
  logic [1:0]    o_valid;
  logic [W-1:0]  o_isn1, o_isn2;
  logic [1:0]    i_pop;
  logic [4:0]    o_count;
`ifdef INSN_QUEUE_STATS_EN
  logic [31:0]   o_stall_cycles;
  int unsigned   stall_m;
  int unsigned   stat_snap;
`endif

  insn_queue #(.INSN_WIDTH(W), .DEPTH(D), .PTR_W(4)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Flush(i_Flush), .i_valid(i_valid),
    .i_isn1(i_isn1), .i_isn2(i_isn2), .i_isn3(i_isn3), .i_isn4(i_isn4),
    .o_Stall(o_Stall), .o_valid(o_valid), .o_isn1(o_isn1), .o_isn2(o_isn2),
    .i_pop(i_pop),
`ifdef INSN_QUEUE_STATS_EN
    .o_stall_cycles(o_stall_cycles),
`endif
    .o_count(o_count)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mq[$];
  int next_tag = 100;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int t);
    return {35'(t * 7 + 3), 32'(t), 32'(t ^ 32'h5A5A_5A5A)};
  endfunction

  function automatic int lead(input logic [3:0] v);
    casez (v)
      4'b0???: return 0;
      4'b10??: return 1;
      4'b110?: return 2;
      4'b1110: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input int n);
    case (n)
      0: return 4'b0000;
      1: return 4'b1000;
      2: return 4'b1100;
      3: return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // One clock: drive, update the scoreboard with the pre-edge state, check after the edge.
  task automatic step(input logic [3:0] v, input logic [1:0] p, input logic f, input logic r);
    int  n, pe, sz;
    bit  st;
    i_valid = v; i_pop = p; i_Flush = f; i_Reset = r;
    i_isn1 = mk(next_tag);     i_isn2 = mk(next_tag + 1);
    i_isn3 = mk(next_tag + 2); i_isn4 = mk(next_tag + 3);
    sz = mq.size();
    st = (D - sz) < 4;
    n  = lead(v);
    pe = (p == 2'b11) ? ((sz >= 2) ? 2 : sz) : (p == 2'b10) ? ((sz >= 1) ? 1 : 0) : 0;
`ifdef INSN_QUEUE_STATS_EN
    if (r) stall_m = 0;
    else if (st && v[3] && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
    @(posedge i_Clk); #1;
    if (r || f) mq.delete();
    else begin
      repeat (pe) void'(mq.pop_front());
      if (!st) begin
        for (int k = 0; k < n; k++) mq.push_back(next_tag + k);
        next_tag += n;
      end
    end
    i_valid = 4'b0000; i_pop = 2'b00; i_Flush = 1'b0; i_Reset = 1'b0;
    sz = mq.size();
    chk("count", 128'(o_count), 128'(sz));
    chk("valid", 128'(o_valid), 128'({sz >= 1, sz >= 2}));
    chk("stall", 128'(o_Stall), 128'((D - sz) < 4));
    if (sz >= 1) chk("isn1", 128'(o_isn1), 128'(mk(mq[0])));
    if (sz >= 2) chk("isn2", 128'(o_isn2), 128'(mk(mq[1])));
`ifdef INSN_QUEUE_STATS_EN
    chk("stall_cycles", 128'(o_stall_cycles), 128'(stall_m));
`endif
  endtask

  initial begin
    int it, base;
    logic [3:0] pat [4] = '{4'b1111, 4'b1110, 4'b1111, 4'b1100};
    i_Reset = 1'b1; i_Flush = 1'b0; i_valid = 4'b1111; i_pop = 2'b00;
    i_isn1 = '0; i_isn2 = '0; i_isn3 = '0; i_isn4 = '0;

    // 1: reset with a full group presented
    step(4'b1111, 2'b00, 1'b0, 1'b1);
    step(4'b1111, 2'b00, 1'b0, 1'b1);
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_stall", 128'(o_Stall), 128'(0));

    // 2: fill to 14, rejected group, then pop two to release stall
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    step(4'b1100, 2'b00, 1'b0, 1'b0);
    chk("fill_count", 128'(o_count), 128'(14));
    chk("fill_stall", 128'(o_Stall), 128'(1));
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    chk("drop_count", 128'(o_count), 128'(14));
`ifdef INSN_QUEUE_STATS_EN
    chk("drop_stat", 128'(o_stall_cycles), 128'(1));
`endif
    step(4'b0000, 2'b11, 1'b0, 1'b0);
    chk("pop_count", 128'(o_count), 128'(12));
    chk("pop_stall", 128'(o_Stall), 128'(0));

    // 3: tags 1..40 streamed through with dual pop every cycle, across pointer wrap
    step(4'b0000, 2'b00, 1'b1, 1'b0);
    next_tag = 1;
    it = 0;
    while (next_tag <= 40 && it < 200) begin
      logic [3:0] m;
      m = pat[it % 4];
      if (lead(m) > 41 - next_tag) m = mask_of(41 - next_tag);
      step(m, 2'b11, 1'b0, 1'b0);
      it++;
    end
    chk("wrap_pushed", 128'(next_tag), 128'(41));
    it = 0;
    while (mq.size() > 0 && it < 50) begin
      step(4'b0000, 2'b11, 1'b0, 1'b0);
      it++;
    end
    chk("wrap_drained", 128'(o_count), 128'(0));

    // 4: simultaneous push of 3 and pop of 2 at count 5
    step(4'b0000, 2'b00, 1'b1, 1'b0);
    base = next_tag;
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    step(4'b1000, 2'b00, 1'b0, 1'b0);
    step(4'b1110, 2'b11, 1'b0, 1'b0);
    chk("sim_count", 128'(o_count), 128'(6));
    chk("sim_isn1", 128'(o_isn1), 128'(mk(base + 2)));

    // 5: non-contiguous mask and over-pop
    step(4'b0000, 2'b00, 1'b1, 1'b0);
    step(4'b1011, 2'b00, 1'b0, 1'b0);
    chk("odd_mask", 128'(o_count), 128'(1));
    step(4'b0000, 2'b01, 1'b0, 1'b0);
    chk("pop01", 128'(o_count), 128'(1));
    step(4'b0000, 2'b11, 1'b0, 1'b0);
    chk("overpop", 128'(o_count), 128'(0));
    step(4'b0000, 2'b11, 1'b0, 1'b0);
    chk("underflow", 128'(o_count), 128'(0));

    // 6: flush beats concurrent push and pop
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    step(4'b1111, 2'b00, 1'b0, 1'b0);
    step(4'b1000, 2'b00, 1'b0, 1'b0);
    chk("pre_flush", 128'(o_count), 128'(9));
`ifdef INSN_QUEUE_STATS_EN
    stat_snap = o_stall_cycles;
`endif
    step(4'b1111, 2'b10, 1'b1, 1'b0);
    chk("flush_count", 128'(o_count), 128'(0));
    chk("flush_valid", 128'(o_valid), 128'(0));
`ifdef INSN_QUEUE_STATS_EN
    chk("flush_stat", 128'(o_stall_cycles), 128'(stat_snap));
`endif
    step(4'b1100, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
